// File: rtl/key_expansion_ctrl_8bit.sv
// Sequencer for an 8-bit serial AES key expansion datapath: loads the key byte by byte,
// then steps the datapath mux selects through NROUNDS round keys of BYTES bytes each.
module key_expansion_ctrl_8bit #(
  parameter int NROUNDS = 10,
  parameter int BYTES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       key_ready,
  output logic       select_input,
  output logic       select_sbox,
  output logic       select_bit_out,
  output logic       select_last_out,
  output logic [7:0] rcon_en,
  output logic [3:0] rcount,
  output logic       rkey_valid,
  output logic       rkey_first,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(BYTES - 1);
  localparam logic [3:0] RND_LAST = 4'(NROUNDS - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] rnd_reg, rnd_next;
  logic       in_round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rnd_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rnd_reg   <= rnd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rnd_next   = rnd_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_next   = 4'd0;
          rnd_next   = 4'd0;
        end
      end
      LOAD: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == CNT_LAST) begin
          state_next = ROUND;
          cnt_next   = 4'd0;
        end
      end
      ROUND: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == CNT_LAST) begin
          cnt_next = 4'd0;
          if (rnd_reg == RND_LAST) begin
            state_next = DONE;
            rnd_next   = 4'd0;
          end else begin
            rnd_next = rnd_reg + 4'd1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort wins over start and every transition, so done can never follow an abort
    if (abort) begin
      state_next = IDLE;
      cnt_next   = 4'd0;
      rnd_next   = 4'd0;
    end
  end

  assign in_round = (state_reg == ROUND);

  always_comb begin
    key_ready       = (state_reg == LOAD);
    busy            = (state_reg == LOAD) || in_round;
    done            = (state_reg == DONE);
    select_input    = in_round;
    rkey_valid      = in_round;
    rkey_first      = in_round && (cnt_reg == 4'd0);
    rcon_en         = (in_round && (cnt_reg == 4'd0)) ? 8'hFF : 8'h00;
    select_sbox     = !(in_round && (cnt_reg == 4'd3));
    select_last_out = !(in_round && (cnt_reg < 4'd4));
    select_bit_out  = in_round && (cnt_reg >= 4'd4);
    rcount          = in_round ? rnd_reg : 4'd0;
  end

endmodule

// File: tb/tb_key_expansion_ctrl_8bit.sv
// Self-checking bench: a cycle-index model predicts every output each cycle, and
// directed sequences pin latency, schedule, abort, re-start and reset behaviour.
module tb_key_expansion_ctrl_8bit;

  localparam int NROUNDS = 10;
  localparam int TOTAL   = 17 + 16 * NROUNDS;  // cycle index of the done pulse

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       key_ready, select_input, select_sbox, select_bit_out, select_last_out;
  logic [7:0] rcon_en;
  logic [3:0] rcount;
  logic       rkey_valid, rkey_first, busy, done;

  int checks   = 0;
  int failures = 0;
  int k        = 0;  // model: cycles since start was accepted, 0 when idle

  key_expansion_ctrl_8bit #(.NROUNDS(NROUNDS), .BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key_ready(key_ready), .select_input(select_input), .select_sbox(select_sbox),
    .select_bit_out(select_bit_out), .select_last_out(select_last_out),
    .rcon_en(rcon_en), .rcount(rcount), .rkey_valid(rkey_valid),
    .rkey_first(rkey_first), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] dut_vec();
    return {key_ready, select_input, select_sbox, select_bit_out, select_last_out,
            rcon_en, rcount, rkey_valid, rkey_first, busy, done};
  endfunction

  // Expected outputs from the position within a schedule.
  function automatic logic [20:0] expect_vec(int idx);
    logic ld, rd, dn, first, sbox, last_out, bit_out;
    logic [7:0] rc;
    logic [3:0] rn;
    int c, r;
    ld = (idx >= 1) && (idx <= 16);
    rd = (idx >= 17) && (idx < TOTAL);
    dn = (idx == TOTAL);
    c  = rd ? (idx - 17) % 16 : 0;
    r  = rd ? (idx - 17) / 16 : 0;
    first    = rd && (c == 0);
    sbox     = !(rd && (c == 3));
    last_out = !(rd && (c < 4));
    bit_out  = rd && (c >= 4);
    rc       = first ? 8'hFF : 8'h00;
    rn       = 4'(r);
    return {ld, rd, sbox, bit_out, last_out, rc, rn, rd, first, ld || rd, dn};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          k <= 0;
    else if (abort)      k <= 0;
    else if (k == 0)     k <= start ? 1 : 0;
    else if (k == TOTAL) k <= 0;
    else                 k <= k + 1;
  end

  always @(negedge clk) begin
    checks++;
    if (dut_vec() !== expect_vec(k)) begin
      failures++;
      $display("FAIL cycle_model k=%0d actual=%h expected=%h", k, dut_vec(), expect_vec(k));
    end
  end

  // Start a schedule and watch 200 cycles; optional re-start pulse and abort point.
  task automatic run_seq(input string name, input int restart_at, input int abort_at);
    int kr = 0, first_rf = 0, done_at = 0, done_n = 0, rf_n = 0, bad_rc = 0, bad_sched = 0;
    int post_abort = -1;
    int c;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (key_ready) kr++;
      if (rkey_first) begin
        if (first_rf == 0) first_rf = n;
        if (rcount != 4'(rf_n)) bad_rc++;
        rf_n++;
      end
      if (done) begin
        done_n++;
        done_at = n;
      end
      if (n >= 81 && n <= 96 && abort_at == 0) begin
        c = n - 81;  // round 4
        if (rcon_en != ((c == 0) ? 8'hFF : 8'h00)) bad_sched++;
        if (select_sbox != (c != 3)) bad_sched++;
        if (select_last_out != (c >= 4)) bad_sched++;
        if (select_bit_out != (c >= 4)) bad_sched++;
        if (rcount != 4'd4) bad_sched++;
      end
      if (n == abort_at + 1) post_abort = {busy, rcount, done, rkey_valid};
      start = (n == restart_at);
      abort = (n == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at == 0) begin
      check({name, "_key_ready_cycles"}, kr, 16);
      check({name, "_first_rkey_first"}, first_rf, 17);
      check({name, "_done_cycle"}, done_at, 177);
      check({name, "_done_count"}, done_n, 1);
      check({name, "_round_count"}, rf_n, NROUNDS);
      check({name, "_rcount_steps"}, bad_rc, 0);
      check({name, "_round4_schedule"}, bad_sched, 0);
      check({name, "_busy_after"}, int'(busy), 0);
    end else begin
      check({name, "_no_done"}, done_n, 0);
      check({name, "_idle_after_abort"}, post_abort, 0);
      check({name, "_rounds_before_abort"}, rf_n, 7);
    end
  endtask

  initial begin
    check("model_idle_pin", int'(expect_vec(0)), int'(21'b0_0_1_0_1_00000000_0000_0_0_0_0));
    check("model_round0_pin", int'(expect_vec(17)), int'(21'b0_1_1_0_0_11111111_0000_1_1_1_0));
    check("model_done_pin", int'(expect_vec(177)), int'(21'b0_0_1_0_1_00000000_0000_0_0_0_1));
    #1;
    check("reset_outputs", int'(dut_vec()), int'(21'b0_0_1_0_1_00000000_0000_0_0_0_0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start and abort together in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", int'(busy), 0);

    run_seq("nominal", 0, 0);
    run_seq("restart_ignored", 54, 0);
    run_seq("abort_r6c7", 0, 120);
    run_seq("after_abort", 0, 0);

    // asynchronous reset mid-LOAD
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(dut_vec()), int'(21'b0_0_1_0_1_00000000_0000_0_0_0_0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_seq("after_reset", 0, 0);

    // randomized start/abort traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(511) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl_8bit.md
KEY_EXPANSION_CTRL_8BIT -- requirements
Module: key_expansion_ctrl_8bit

Interface
REQ-001 Parameter NROUNDS, default 10, is the number of round keys generated after the load phase.
REQ-002 Parameter BYTES, default 16, is the number of bytes per key and round key; the cycle counter width is 4 bits.
REQ-003 clk  input  1  rising-edge clock, shared with the 8-bit key expansion datapath.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a key schedule; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel; returns the block to IDLE from any state.
REQ-007 key_ready  output  1  high while the datapath is consuming input_key bytes.
REQ-008 select_input  output  1  mux_in select: 0 selects input_key, 1 selects last_rkey.
REQ-009 select_sbox  output  1  mux_sbox select: 0 selects r_sbox, 1 selects r13.
REQ-010 select_bit_out  output  1  mux_bit select: 0 selects r4, 1 selects r4^last_rkey.
REQ-011 select_last_out  output  1  mux_last_out select: 0 selects r0^sbox^rcon, 1 selects r0.
REQ-012 rcon_en  output  8  8'hFF enables the round constant and r_sbox capture; otherwise 8'h00.
REQ-013 rcount  output  4  current round index, 0..NROUNDS-1.
REQ-014 rkey_valid  output  1  high when last_rkey carries a byte of the current round key.
REQ-015 rkey_first  output  1  high with rkey_valid on byte 0 of each round key.
REQ-016 busy  output  1  high in LOAD and ROUND.
REQ-017 done  output  1  one-cycle pulse after the final round key byte.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, ROUND and DONE.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge, with the byte counter cnt=0 and the round counter rnd=0.
REQ-020 LOAD SHALL last exactly BYTES cycles (cnt 0..15), with key_ready=1 and select_input=0; at cnt=15 the FSM SHALL go to ROUND with cnt=0.
REQ-021 In ROUND, cnt SHALL increment every cycle and wrap 15->0; on the wrap, rnd SHALL increment.
REQ-022 When rnd=NROUNDS-1 and cnt=15, the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 Per-byte schedule in ROUND:
- select_input=1 throughout.
- rcon_en=8'hFF at cnt=0 only.
- select_sbox=0 at cnt=3, otherwise 1.
- select_last_out=0 for cnt 0..3, otherwise 1.
- select_bit_out=1 for cnt 4..15, otherwise 0.
REQ-025 rcount SHALL equal rnd in ROUND and be 0 in all other states.
REQ-026 rkey_valid SHALL be 1 for every ROUND cycle, and rkey_first SHALL equal (ROUND && cnt==0).
REQ-027 Outside ROUND the outputs SHALL be: rcon_en=8'h00, select_sbox=1, select_last_out=1, select_bit_out=0, rkey_valid=0 and rkey_first=0.
REQ-028 select_input SHALL be 0 outside ROUND.
REQ-029 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from start or abort to any output.
REQ-030 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-031 abort SHALL take priority over start and over all state transitions; abort=1 SHALL force IDLE, cnt=0 and rnd=0 on the next edge, and done SHALL NOT pulse.
REQ-032 start and abort asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-033 Latency: start accepted at edge T gives key_ready high for edges T+1..T+16, the first rkey_first at T+17, and done at T+17+16*NROUNDS (T+177 with the defaults).

Reset
REQ-034 rst_n=0 SHALL immediately, independent of clk, force: state=IDLE, cnt=0, rnd=0.
REQ-035 rst_n=0 SHALL immediately force the outputs to: key_ready=0, busy=0, done=0, rkey_valid=0, rkey_first=0, select_input=0, select_sbox=1, select_last_out=1, select_bit_out=0, rcon_en=8'h00, rcount=0.
REQ-036 Reset asserted mid-LOAD or mid-ROUND SHALL discard all progress, and the block SHALL accept a new start on the first edge after rst_n rises.

Verification
REQ-037 Nominal: start pulse in IDLE -> key_ready for 16 cycles; 160 ROUND cycles with rcount stepping 0..9 every 16 cycles; done at T+177; busy low afterwards.
REQ-038 Schedule check: during round 4 -> rcon_en=8'hFF only at cnt=0, select_sbox=0 only at cnt=3, select_last_out=0 at cnt 0..3, select_bit_out=1 at cnt 4..15.
REQ-039 FIPS-197 key 2b7e1516...09cf4f3c loaded through the datapath -> last round key bytes d0,14,f9,a8,...,0c,a6 on last_rkey while rnd=9.
REQ-040 start re-pulsed at cnt=5 of round 2 -> ignored; done still occurs exactly once at T+177.
REQ-041 abort at cnt=7 of round 6 -> IDLE on the next edge, done=0, rcount=0; a following start gives a full nominal sequence.
REQ-042 rst_n low for 3 cycles mid-LOAD -> all outputs at their reset values asynchronously; start after release gives the nominal timing.
